// File: rtl/addc_pkg.sv
// Shared types and the masked chunk adder for the serial add-with-carry unit.
package addc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } addc_state_t;

   localparam int unsigned MAX_CHUNK = 64;
   localparam int unsigned CW_W      = $clog2(MAX_CHUNK + 1);

   // Adds the low w bits of x and y plus ci; bits above w are masked off and
   // the carry out of bit w-1 is returned through co.
   function automatic logic [MAX_CHUNK-1:0] add_chunk(
      input  logic [MAX_CHUNK-1:0] x,
      input  logic [MAX_CHUNK-1:0] y,
      input  logic                 ci,
      input  logic [CW_W-1:0]      w,
      output logic                 co
   );
      logic [MAX_CHUNK:0] mask;
      logic [MAX_CHUNK:0] t;
      mask = ({{MAX_CHUNK{1'b0}}, 1'b1} << w) - 1'b1;
      t    = {1'b0, x & mask[MAX_CHUNK-1:0]}
           + {1'b0, y & mask[MAX_CHUNK-1:0]}
           + {{MAX_CHUNK{1'b0}}, ci};
      co   = t[w];
      return t[MAX_CHUNK-1:0] & mask[MAX_CHUNK-1:0];
   endfunction

endpackage

// File: rtl/addc_slice.sv
// Combinational CHUNK-bit adder with carry-in and carry-out.
module addc_slice
   import addc_pkg::*;
#(
   parameter int unsigned CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co
);

   logic [MAX_CHUNK-1:0] ax;
   logic [MAX_CHUNK-1:0] bx;
   logic [MAX_CHUNK-1:0] sx;
   logic                 c;

   always_comb begin
      ax             = '0;
      bx             = '0;
      ax[CHUNK-1:0]  = a;
      bx[CHUNK-1:0]  = b;
      c              = 1'b0;
      sx             = add_chunk(ax, bx, ci, CW_W'(CHUNK), c);
      s              = sx[CHUNK-1:0];
      co             = c;
   end

endmodule

// File: rtl/addc_serial.sv
// Multi-cycle add-with-carry, CHUNK bits per clock, valid/ready on both sides.
// Optional signed-overflow output enabled by defining ADDC_OVF_EN.
module addc_serial
   import addc_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef ADDC_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned NCH  = WIDTH / CHUNK;
   localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IDXW-1:0] LAST = IDXW'(NCH - 1);

   if ((CHUNK == 0) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
      $error("addc_serial: WIDTH must be a non-zero multiple of CHUNK");
   end
   if (CHUNK > MAX_CHUNK) begin : g_bad_max
      $error("addc_serial: CHUNK exceeds MAX_CHUNK");
   end

   addc_state_t      state, state_nx;
   logic [IDXW-1:0]  idx;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] sum_r;
   logic             carry_r;

   logic [CHUNK-1:0] a_sl;
   logic [CHUNK-1:0] b_sl;
   logic [CHUNK-1:0] s_sl;
   logic             co_sl;

   always_comb begin
      a_sl = a_r[idx*CHUNK +: CHUNK];
      b_sl = b_r[idx*CHUNK +: CHUNK];
   end

   addc_slice #(.CHUNK(CHUNK)) u_slice (
      .a  (a_sl),
      .b  (b_sl),
      .ci (carry_r),
      .s  (s_sl),
      .co (co_sl)
   );

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (in_valid)     state_nx = RUN;
         RUN:  if (idx == LAST)  state_nx = DONE;
         DONE: if (out_ready)    state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         a_r     <= '0;
         b_r     <= '0;
         sum_r   <= '0;
         carry_r <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (in_valid) begin
               a_r     <= a;
               b_r     <= b;
               carry_r <= cin;
               sum_r   <= '0;
               idx     <= '0;
            end
            RUN: begin
               sum_r[idx*CHUNK +: CHUNK] <= s_sl;
               carry_r                   <= co_sl;
               idx                       <= (idx == LAST) ? '0 : idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      sum       = sum_r;
      cout      = carry_r;
   end

`ifdef ADDC_OVF_EN
   always_comb begin
      ovf = (state == DONE) && (a_r[WIDTH-1] == b_r[WIDTH-1])
                            && (sum_r[WIDTH-1] != a_r[WIDTH-1]);
   end
`endif

endmodule

// File: tb/tb_addc_serial.sv
// Directed self-checking bench for addc_serial (CHUNK=8 and CHUNK=32 instances).
module tb_addc_serial;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, out_ready;
   logic        in_valid32, out_ready32;
   logic [31:0] a, b;
   logic        cin;
   logic        in_ready, out_valid, cout;
   logic        in_ready32, out_valid32, cout32;
   logic [31:0] sum, sum32;
`ifdef ADDC_OVF_EN
   logic        ovf, ovf32;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   addc_serial #(.WIDTH(32), .CHUNK(8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout)
`ifdef ADDC_OVF_EN
      , .ovf(ovf)
`endif
   );

   addc_serial #(.WIDTH(32), .CHUNK(32)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid32), .out_ready(out_ready32),
      .sum(sum32), .cout(cout32)
`ifdef ADDC_OVF_EN
      , .ovf(ovf32)
`endif
   );

   // Drives one accept cycle; returns #1 after the accept edge.
   task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic cv);
      a = av; b = bv; cin = cv; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 32'hDEAD_BEEF; b = 32'h5555_AAAA; cin = ~cv;
   endtask

   // Counts edges until out_valid, -1 if the bound expires.
   task automatic wait_valid(output int n);
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (out_valid !== 1'b1) n = -1;
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (sum !== 32'h0)      begin errors++; $display("FAIL reset_sum got=%h exp=0", sum); end
      checks++; if (cout !== 1'b0)      begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
      checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL reset_in_ready32 got=%b exp=1", in_ready32); end
   endtask

   task automatic test_vectors();
      logic [31:0] va [7], vb [7], vs [7];
      logic        vc [7], vo [7];
      int          n;
      va[0]=32'h0000_0001; vb[0]=32'h0000_0002; vc[0]=0; vs[0]=32'h0000_0003; vo[0]=0;
      va[1]=32'hFFFF_FFFF; vb[1]=32'h0000_0001; vc[1]=0; vs[1]=32'h0000_0000; vo[1]=1;
      va[2]=32'h0000_0000; vb[2]=32'h0000_0000; vc[2]=1; vs[2]=32'h0000_0001; vo[2]=0;
      va[3]=32'hFFFF_FFFF; vb[3]=32'h0000_0000; vc[3]=1; vs[3]=32'h0000_0000; vo[3]=1;
      va[4]=32'h7FFF_FFFF; vb[4]=32'h0000_0001; vc[4]=0; vs[4]=32'h8000_0000; vo[4]=0;
      va[5]=32'h1234_5678; vb[5]=32'h9ABC_DEF0; vc[5]=1; vs[5]=32'hACF1_3569; vo[5]=0;
      va[6]=32'h8000_0000; vb[6]=32'h8000_0000; vc[6]=0; vs[6]=32'h0000_0000; vo[6]=1;
      for (int i = 0; i < 7; i++) begin
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL vec%0d_in_ready got=%b exp=1", i, in_ready); end
         start_op(va[i], vb[i], vc[i]);
         wait_valid(n);
         checks++; if (n != 4)        begin errors++; $display("FAIL vec%0d_latency got=%0d exp=4", i, n); end
         checks++; if (sum !== vs[i]) begin errors++; $display("FAIL vec%0d_sum got=%h exp=%h", i, sum, vs[i]); end
         checks++; if (cout !== vo[i]) begin errors++; $display("FAIL vec%0d_cout got=%b exp=%b", i, cout, vo[i]); end
`ifdef ADDC_OVF_EN
         checks++;
         if (ovf !== (i == 4 || i == 6)) begin
            errors++; $display("FAIL vec%0d_ovf got=%b exp=%b", i, ovf, (i == 4 || i == 6));
         end
`endif
         take_result();
      end
   endtask

   task automatic test_backpressure();
      int n;
      start_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
      wait_valid(n);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 32'h0000_0100 || cout !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d got valid=%b ready=%b sum=%h cout=%b exp 1 0 00000100 0",
                     k, out_valid, in_ready, sum, cout);
         end
      end
      take_result();
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_mid_run();
      int n;
      start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
      checks++; if (sum !== 32'h0)      begin errors++; $display("FAIL midrst_sum got=%h exp=0", sum); end
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
      checks++; if (cout !== 1'b0)      begin errors++; $display("FAIL midrst_cout got=%b exp=0", cout); end
      start_op(32'd5, 32'd7, 1'b0);
      wait_valid(n);
      checks++; if (n != 4)          begin errors++; $display("FAIL midrst_latency got=%0d exp=4", n); end
      checks++; if (sum !== 32'd12)  begin errors++; $display("FAIL midrst_sum12 got=%h exp=0000000c", sum); end
      take_result();
   endtask

   task automatic test_chunk32();
      a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b1; in_valid32 = 1'b1;
      @(posedge clk); #1;
      in_valid32 = 1'b0;
      a = '0; b = '0; cin = 1'b0;
      checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL c32_run_valid got=%b exp=0", out_valid32); end
      @(posedge clk); #1;
      checks++; if (out_valid32 !== 1'b1) begin errors++; $display("FAIL c32_latency got=%b exp=1", out_valid32); end
      checks++; if (sum32 !== 32'h0000_0001) begin errors++; $display("FAIL c32_sum got=%h exp=00000001", sum32); end
      checks++; if (cout32 !== 1'b1)         begin errors++; $display("FAIL c32_cout got=%b exp=1", cout32); end
      out_ready32 = 1'b1;
      @(posedge clk); #1;
      out_ready32 = 1'b0;
      checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL c32_release got=%b exp=1", in_ready32); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_valid32 = 1'b0; out_ready32 = 1'b0;
      a = '0; b = '0; cin = 1'b0;
      test_reset();
      test_vectors();
      test_backpressure();
      test_reset_mid_run();
      test_chunk32();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
